sparq_pingpong_in_buffer: RTL and testbench

- Parametrised multi-bank (ping-pong generalised to N banks) staging buffer for systolic-array operand tiles (A, A-meta or B side).
- Replaces the single flat input buffer, which had a valid-only write port and no tile ownership.
- Producer (AXI-stream loader) fills one bank while the array skew logic reads a completed bank.
- Adds in_ready backpressure, per-bank tile length, in-order hand-over and a release handshake.

---
 rtl/sparq_pingpong_in_buffer_pkg.sv | 21 ++
 rtl/sparq_pingpong_in_buffer_if.sv | 47 ++++
 rtl/sparq_pingpong_in_buffer_bank_ram.sv | 33 +++
 rtl/sparq_pingpong_in_buffer.sv | 155 +++++++++++++++
 tb/tb_sparq_pingpong_in_buffer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sparq_pingpong_in_buffer_pkg.sv
// Shared types and helpers for the multi-bank operand staging buffer.
package sparq_pingpong_in_buffer_pkg;

  // Ownership of one bank: empty, being filled by the loader, or holding a
  // complete tile waiting for the array.
  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_READY   = 2'd2
  } BankState;

  // Default bank count (classic ping-pong).
  localparam int IN_BANKS = 2;

  // Index width for n entries; never returns 0 so single-entry cases still
  // get a legal one-bit index.
  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sparq_pingpong_in_buffer_if.sv
// Producer write port and consumer read/release port of the staging buffer.
interface sparq_pingpong_in_buffer_if
  import sparq_pingpong_in_buffer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int WORDS     = 16,
  parameter int DEPTH     = 64,
  parameter int NUM_BANKS = IN_BANKS
);
  localparam int DW = WIDTH * WORDS;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = addr_bits(DEPTH);
  localparam int CW = $clog2(NUM_BANKS + 1);

  // producer side
  logic [LW-1:0] fill_len;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  // consumer side
  logic          tile_avail;
  logic [LW-1:0] tile_len;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          tile_release;
  // status
  logic [CW-1:0] ready_count;
  logic          err_rd;
  logic          err_release;

  // Loader + array skew logic view.
  modport master (
    output fill_len, in_valid, in_data, rd_en, rd_addr, tile_release,
    input  in_ready, tile_avail, tile_len, rd_valid, rd_data,
           ready_count, err_rd, err_release
  );

  // Buffer view.
  modport slave (
    input  fill_len, in_valid, in_data, rd_en, rd_addr, tile_release,
    output in_ready, tile_avail, tile_len, rd_valid, rd_data,
           ready_count, err_rd, err_release
  );

endinterface

// File: rtl/sparq_pingpong_in_buffer_bank_ram.sv
// Simple dual-port RAM holding every bank back to back ({bank,row} address),
// with a registered read that only updates when a read is accepted so the
// last returned row stays on the output.
module sparq_bank_ram #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_reg;

  // Write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, held between accepted reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_reg <= '0;
    else if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sparq_pingpong_in_buffer.sv
// N-bank staging buffer for systolic-array operand tiles. The loader fills
// banks in ring order; the array reads and releases them in the same order.
module sparq_pingpong_in_buffer
  import sparq_pingpong_in_buffer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int WORDS     = 16,
  parameter int DEPTH     = 64,
  parameter int NUM_BANKS = IN_BANKS
) (
  input  logic                         clk,
  input  logic                         rst,
  sparq_pingpong_in_buffer_if.slave    bus
);
  localparam int DW = WIDTH * WORDS;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = addr_bits(DEPTH);
  localparam int BW = addr_bits(NUM_BANKS);
  localparam int CW = $clog2(NUM_BANKS + 1);

  BankState       state_reg [NUM_BANKS];
  BankState       state_next[NUM_BANKS];
  logic [LW-1:0]  len_reg   [NUM_BANKS];
  logic [LW-1:0]  len_next  [NUM_BANKS];
  logic [BW-1:0]  wbank_reg, wbank_next;
  logic [BW-1:0]  rbank_reg, rbank_next;
  logic [AW-1:0]  wrow_reg,  wrow_next;
  logic           rd_valid_reg, err_rd_reg, err_release_reg;

  BankState       wstate, rstate;
  logic [LW-1:0]  eff_len;
  logic           in_ready, beat, last_beat;
  logic           tile_avail, rd_ok, release_ok;
  logic [NUM_BANKS-1:0] bank_ready;
  logic [CW-1:0]  ready_count;
  logic [DW-1:0]  ram_rdata;

  assign wstate = state_reg[wbank_reg];
  assign rstate = state_reg[rbank_reg];

  // A FREE bank needs a non-zero length to start; a READY bank blocks the
  // loader until the consumer hands it back.
  assign in_ready = !rst && (wstate != BANK_READY) &&
                    ((wstate == BANK_FILLING) || (bus.fill_len != '0));
  assign beat     = bus.in_valid && in_ready;

  // On the first beat the length is still on fill_len, not yet in len_reg.
  assign eff_len   = (wstate == BANK_FILLING) ? len_reg[wbank_reg] : bus.fill_len;
  assign last_beat = beat && (LW'(wrow_reg) == (eff_len - LW'(1)));

  assign tile_avail = (rstate == BANK_READY);
  assign rd_ok      = bus.rd_en && tile_avail && (LW'(bus.rd_addr) < len_reg[rbank_reg]);
  assign release_ok = bus.tile_release && tile_avail;

  // Next-state for bank ownership, lengths and ring pointers. Fill completion
  // and release always hit different banks (READY banks refuse writes).
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    wbank_next = wbank_reg;
    rbank_next = rbank_reg;
    wrow_next  = wrow_reg;
    if (beat) begin
      if (wstate == BANK_FREE) begin
        len_next[wbank_reg]   = bus.fill_len;
        state_next[wbank_reg] = BANK_FILLING;
      end
      if (last_beat) begin
        state_next[wbank_reg] = BANK_READY;
        wbank_next            = wbank_reg + BW'(1);
        wrow_next             = '0;
      end else begin
        wrow_next = wrow_reg + AW'(1);
      end
    end
    if (release_ok) begin
      state_next[rbank_reg] = BANK_FREE;
      rbank_next            = rbank_reg + BW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      // Per-bank ownership state and tile length.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg[gi] <= BANK_FREE;
          len_reg[gi]   <= '0;
        end else begin
          state_reg[gi] <= state_next[gi];
          len_reg[gi]   <= len_next[gi];
        end
      end
      assign bank_ready[gi] = (state_reg[gi] == BANK_READY);
    end
  endgenerate

  // Ring pointers and write row counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_reg <= '0;
      rbank_reg <= '0;
      wrow_reg  <= '0;
    end else begin
      wbank_reg <= wbank_next;
      rbank_reg <= rbank_next;
      wrow_reg  <= wrow_next;
    end
  end

  // Read-valid strobe and sticky protocol error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_reg    <= 1'b0;
      err_rd_reg      <= 1'b0;
      err_release_reg <= 1'b0;
    end else begin
      rd_valid_reg    <= rd_ok;
      err_rd_reg      <= err_rd_reg | (bus.rd_en && !rd_ok);
      err_release_reg <= err_release_reg | (bus.tile_release && !tile_avail);
    end
  end

  // Count of READY banks, derived from the registered state.
  always_comb begin
    ready_count = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      ready_count = ready_count + CW'(bank_ready[i]);
    end
  end

  sparq_bank_ram #(
    .DATA_W (DW),
    .ADDR_W (BW + AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (beat),
    .waddr ({wbank_reg, wrow_reg}),
    .wdata (bus.in_data),
    .re    (rd_ok),
    .raddr ({rbank_reg, bus.rd_addr}),
    .rdata (ram_rdata)
  );

  assign bus.in_ready    = in_ready;
  assign bus.tile_avail  = tile_avail;
  assign bus.tile_len    = len_reg[rbank_reg];
  assign bus.rd_valid    = rd_valid_reg;
  assign bus.rd_data     = ram_rdata;
  assign bus.ready_count = ready_count;
  assign bus.err_rd      = err_rd_reg;
  assign bus.err_release = err_release_reg;

endmodule

// File: tb/tb_sparq_pingpong_in_buffer.sv
// Directed bench: a 2-bank instance covers fill/read, backpressure,
// simultaneous fill+release, errors and reset; a 4-bank instance covers
// ring wrap-around. Both share stimulus; the idle one is held in reset.
module tb_sparq_pingpong_in_buffer;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic sel;  // 0: 2-bank instance observed, 1: 4-bank instance observed

  always #5 clk = ~clk;

  sparq_pingpong_in_buffer_if #(.WIDTH(8), .WORDS(2), .DEPTH(8), .NUM_BANKS(2)) a_if ();
  sparq_pingpong_in_buffer_if #(.WIDTH(8), .WORDS(2), .DEPTH(8), .NUM_BANKS(4)) b_if ();

  sparq_pingpong_in_buffer #(.WIDTH(8), .WORDS(2), .DEPTH(8), .NUM_BANKS(2)) dut_a (
    .clk (clk), .rst (rst_a), .bus (a_if.slave)
  );
  sparq_pingpong_in_buffer #(.WIDTH(8), .WORDS(2), .DEPTH(8), .NUM_BANKS(4)) dut_b (
    .clk (clk), .rst (rst_b), .bus (b_if.slave)
  );

  // shared stimulus
  logic [3:0]  fill_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic        tile_release;

  assign a_if.fill_len = fill_len;     assign b_if.fill_len = fill_len;
  assign a_if.in_valid = in_valid;     assign b_if.in_valid = in_valid;
  assign a_if.in_data  = in_data;      assign b_if.in_data  = in_data;
  assign a_if.rd_en    = rd_en;        assign b_if.rd_en    = rd_en;
  assign a_if.rd_addr  = rd_addr;      assign b_if.rd_addr  = rd_addr;
  assign a_if.tile_release = tile_release;
  assign b_if.tile_release = tile_release;

  // observed outputs of the selected instance
  logic        o_in_ready, o_tile_avail, o_rd_valid, o_err_rd, o_err_release;
  logic [3:0]  o_tile_len;
  logic [15:0] o_rd_data;
  logic [2:0]  o_ready_count;

  assign o_in_ready    = sel ? b_if.in_ready    : a_if.in_ready;
  assign o_tile_avail  = sel ? b_if.tile_avail  : a_if.tile_avail;
  assign o_rd_valid    = sel ? b_if.rd_valid    : a_if.rd_valid;
  assign o_err_rd      = sel ? b_if.err_rd      : a_if.err_rd;
  assign o_err_release = sel ? b_if.err_release : a_if.err_release;
  assign o_tile_len    = sel ? b_if.tile_len    : a_if.tile_len;
  assign o_rd_data     = sel ? b_if.rd_data     : a_if.rd_data;
  assign o_ready_count = sel ? b_if.ready_count : {1'b0, a_if.ready_count};

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Row payload: tile number in the high nibble, row in the low nibble, and
  // an inverted copy so both words of the row are distinct.
  function automatic logic [15:0] mk(input int t, input int r);
    logic [7:0] b;
    b = 8'(t * 16 + r);
    return {b, b ^ 8'hA5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream one tile; optionally release the read bank on the last beat.
  task automatic write_tile(input int t, input int len, input bit rel_last);
    fill_len = 4'(len);
    in_valid = 1'b1;
    for (int r = 0; r < len; r++) begin
      in_data = mk(t, r);
      tile_release = rel_last && (r == len - 1);
      #1;
      check_eq($sformatf("in_ready t%0d r%0d", t, r), 32'(o_in_ready), 32'd1);
      tick();
    end
    in_valid     = 1'b0;
    tile_release = 1'b0;
    $display("fill tile %0d len %0d release_on_last=%0d", t, len, rel_last);
  endtask

  // Read a whole tile back-to-back and optionally release it afterwards.
  task automatic read_tile(input int t, input int len, input bit rel);
    check_eq($sformatf("tile_avail t%0d", t), 32'(o_tile_avail), 32'd1);
    check_eq($sformatf("tile_len t%0d", t), 32'(o_tile_len), 32'(len));
    for (int r = 0; r < len; r++) begin
      rd_en   = 1'b1;
      rd_addr = 3'(r);
      tick();
      check_eq($sformatf("rd_valid t%0d r%0d", t, r), 32'(o_rd_valid), 32'd1);
      check_eq($sformatf("rd_data t%0d r%0d", t, r), 32'(o_rd_data), 32'(mk(t, r)));
    end
    rd_en = 1'b0;
    if (rel) tile_release = 1'b1;
    tick();
    tile_release = 1'b0;
    check_eq($sformatf("rd_valid idle t%0d", t), 32'(o_rd_valid), 32'd0);
    $display("read tile %0d len %0d released=%0d", t, len, rel);
  endtask

  initial begin
    sel = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    fill_len = 4'd4; in_valid = 1'b1; in_data = 16'hFFFF;
    rd_en = 1'b0; rd_addr = '0; tile_release = 1'b0;

    // reset state (fill_len non-zero so in_ready gating by rst is visible)
    tick(); tick();
    check_eq("rst in_ready", 32'(o_in_ready), 32'd0);
    check_eq("rst tile_avail", 32'(o_tile_avail), 32'd0);
    check_eq("rst ready_count", 32'(o_ready_count), 32'd0);
    check_eq("rst rd_valid", 32'(o_rd_valid), 32'd0);
    check_eq("rst rd_data", 32'(o_rd_data), 32'd0);
    check_eq("rst err_rd", 32'(o_err_rd), 32'd0);
    check_eq("rst err_release", 32'(o_err_release), 32'd0);
    in_valid = 1'b0;
    rst_a = 1'b0;
    tick();

    // basic fill and read (bank0)
    write_tile(0, 4, 1'b0);
    check_eq("t1 ready_count", 32'(o_ready_count), 32'd1);
    read_tile(0, 4, 1'b1);
    check_eq("t1 ready_count after rel", 32'(o_ready_count), 32'd0);

    // backpressure: both banks full, held beat must wait
    write_tile(1, 2, 1'b0);
    write_tile(2, 2, 1'b0);
    check_eq("bp ready_count", 32'(o_ready_count), 32'd2);
    fill_len = 4'd1; in_valid = 1'b1; in_data = mk(3, 0);
    #1;
    check_eq("bp in_ready full", 32'(o_in_ready), 32'd0);
    tick();
    check_eq("bp in_ready held", 32'(o_in_ready), 32'd0);
    tile_release = 1'b1;
    #1;
    check_eq("bp in_ready release cycle", 32'(o_in_ready), 32'd0);
    tick();
    tile_release = 1'b0;
    check_eq("bp in_ready after rel", 32'(o_in_ready), 32'd1);
    check_eq("bp ready_count after rel", 32'(o_ready_count), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("bp ready_count after beat", 32'(o_ready_count), 32'd2);
    read_tile(2, 2, 1'b1);
    read_tile(3, 1, 1'b0);

    // simultaneous fill-complete and release on different banks
    write_tile(4, 2, 1'b1);
    check_eq("sim ready_count", 32'(o_ready_count), 32'd1);
    check_eq("sim tile_avail", 32'(o_tile_avail), 32'd1);
    check_eq("sim tile_len", 32'(o_tile_len), 32'd2);
    read_tile(4, 2, 1'b1);
    check_eq("err_rd clean", 32'(o_err_rd), 32'd0);
    check_eq("err_release clean", 32'(o_err_release), 32'd0);

    // errors
    tile_release = 1'b1;
    tick();
    tile_release = 1'b0;
    check_eq("err_release set", 32'(o_err_release), 32'd1);
    check_eq("err empty tile_avail", 32'(o_tile_avail), 32'd0);
    fill_len = 4'd0; in_valid = 1'b1; in_data = 16'hDEAD;
    #1;
    check_eq("fill_len0 in_ready", 32'(o_in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    check_eq("fill_len0 ready_count", 32'(o_ready_count), 32'd0);
    write_tile(5, 4, 1'b0);
    rd_en = 1'b1; rd_addr = 3'd3;
    tick();
    check_eq("err pre rd_valid", 32'(o_rd_valid), 32'd1);
    rd_addr = 3'd5;
    tick();
    rd_en = 1'b0;
    check_eq("err rd_valid", 32'(o_rd_valid), 32'd0);
    check_eq("err rd_data held", 32'(o_rd_data), 32'(mk(5, 3)));
    check_eq("err_rd set", 32'(o_err_rd), 32'd1);
    read_tile(5, 4, 1'b1);

    // reset mid-fill with a READY tile present
    write_tile(7, 2, 1'b0);
    fill_len = 4'd4; in_valid = 1'b1;
    for (int r = 0; r < 2; r++) begin
      in_data = mk(6, r);
      tick();
    end
    rst_a = 1'b1;
    #1;
    check_eq("mid rst in_ready", 32'(o_in_ready), 32'd0);
    check_eq("mid rst tile_avail", 32'(o_tile_avail), 32'd0);
    check_eq("mid rst ready_count", 32'(o_ready_count), 32'd0);
    check_eq("mid rst err_rd", 32'(o_err_rd), 32'd0);
    in_valid = 1'b0;
    tick();
    rst_a = 1'b0;
    tick();
    write_tile(8, 3, 1'b0);
    check_eq("post rst ready_count", 32'(o_ready_count), 32'd1);
    read_tile(8, 3, 1'b1);

    // 4-bank wrap-around
    rst_a = 1'b1;
    rst_b = 1'b0;
    sel   = 1'b1;
    tick();
    write_tile(10, 1, 1'b0);
    write_tile(11, 2, 1'b0);
    write_tile(12, 3, 1'b0);
    check_eq("wrap ready_count 3", 32'(o_ready_count), 32'd3);
    read_tile(10, 1, 1'b1);
    write_tile(13, 4, 1'b0);
    write_tile(14, 5, 1'b0);
    check_eq("wrap ready_count 4", 32'(o_ready_count), 32'd4);
    fill_len = 4'd6;
    #1;
    check_eq("wrap in_ready full", 32'(o_in_ready), 32'd0);
    read_tile(11, 2, 1'b1);
    read_tile(12, 3, 1'b1);
    read_tile(13, 4, 1'b1);
    write_tile(15, 6, 1'b0);
    read_tile(14, 5, 1'b1);
    read_tile(15, 6, 1'b1);
    check_eq("wrap ready_count 0", 32'(o_ready_count), 32'd0);
    check_eq("wrap err_rd", 32'(o_err_rd), 32'd0);
    check_eq("wrap err_release", 32'(o_err_release), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
